// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the fetch stage and its F/D register.
package fetch_stage_pkg;

  localparam logic [31:0] EXC_INIT = 32'h0000_4180;
  localparam logic [31:0] PC_INIT  = 32'h0000_3000;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_NONE = 5'd0;

  // Fetch address error: misaligned or outside instruction memory.
  function automatic logic is_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  endfunction

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register: reset > flush > stall hold > squash > capture.
module fd_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] FLUSH_PC = EXC_INIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        squash_i,
  input  logic        bd_i,
  input  logic        adel_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [4:0]  exc_o,
  output logic        bd_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  exc_q, exc_d;
  logic        bd_q, bd_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    if (flush_i) begin
      instr_d = 32'd0;
      pc_d    = FLUSH_PC;
      exc_d   = EXC_NONE;
      bd_d    = 1'b0;
    end else if (!stall_i) begin
      if (squash_i) begin
        // The slot behind an eret becomes a bubble that still carries its PC.
        instr_d = 32'd0;
        pc_d    = pc_i;
        exc_d   = EXC_NONE;
        bd_d    = 1'b0;
      end else begin
        instr_d = adel_i ? 32'd0 : instr_i;
        pc_d    = pc_i;
        exc_d   = adel_i ? EXC_ADEL : EXC_NONE;
        bd_d    = bd_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= 32'd0;
      pc_q    <= PC_INIT;
      exc_q   <= EXC_NONE;
      bd_q    <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign exc_o   = exc_q;
  assign bd_o    = bd_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS fetch stage: PC register, next-PC select, AdEL check and F/D register.
// Optional FETCH_STAT_EN adds fetch_cnt / stall_cnt statistics outputs.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret_D,
  input  logic        bd_in,
  input  logic [31:0] npc,
  input  logic [31:0] instr_F,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [4:0]  excCode_D,
`ifdef FETCH_STAT_EN
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
`endif
  output logic        bd_D
);

  logic [31:0] pc_q, pc_d;
  logic        adel_F;

  // An exception request redirects even while the hazard unit stalls.
  always_comb begin
    pc_d = pc_q;
    if (req)
      pc_d = npc;
    else if (!stall)
      pc_d = (npc != 32'd0) ? npc : pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= PC_INIT;
    else       pc_q <= pc_d;
  end

  assign pc_F   = pc_q;
  assign adel_F = is_adel(pc_q);

  fd_reg #(.FLUSH_PC(EXC_INIT)) u_fd_reg (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (req),
    .stall_i  (stall),
    .squash_i (eret_D),
    .bd_i     (bd_in),
    .adel_i   (adel_F),
    .instr_i  (instr_F),
    .pc_i     (pc_q),
    .instr_o  (instr_D),
    .pc_o     (pc_D),
    .exc_o    (excCode_D),
    .bd_o     (bd_D)
  );

`ifdef FETCH_STAT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!req && !stall && !eret_D && !adel_F) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (stall && !req)                        stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed plan, then random traffic vs a reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, req, eret_D, bd_in;
  logic [31:0] npc, instr_F, pc_F, instr_D, pc_D;
  logic [4:0]  excCode_D;
  logic        bd_D;
`ifdef FETCH_STAT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // clock
  always #5 clk = ~clk;

  // instruction memory image: any distinct function of the address
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign instr_F = imem(pc_F);

  fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .req       (req),
    .eret_D    (eret_D),
    .bd_in     (bd_in),
    .npc       (npc),
    .instr_F   (instr_F),
    .pc_F      (pc_F),
    .instr_D   (instr_D),
    .pc_D      (pc_D),
    .excCode_D (excCode_D),
`ifdef FETCH_STAT_EN
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt),
`endif
    .bd_D      (bd_D)
  );

  // reference model state
  logic [31:0] m_pc, m_instr, m_pcd, m_fc, m_sc;
  logic [4:0]  m_exc;
  logic        m_bd;
  logic [69:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: apply one cycle of inputs, advance the model, compare after the edge
  task automatic step(input logic r, input logic s, input logic q, input logic e,
                      input logic b, input logic [31:0] n);
    logic        adel;
    logic [69:0] item;
    reset = r; stall = s; req = q; eret_D = e; bd_in = b; npc = n;
    adel = (m_pc[1:0] != 2'b00) || (m_pc < 32'h3000) || (m_pc > 32'h6FFC);
    if (r) begin
      m_pc = 32'h3000; m_instr = 0; m_pcd = 32'h3000; m_exc = 0; m_bd = 0;
      m_fc = 0; m_sc = 0;
    end else if (q) begin
      m_instr = 0; m_pcd = 32'h4180; m_exc = 0; m_bd = 0;
      m_pc = n;
    end else if (s) begin
      m_sc = m_sc + 1;
    end else begin
      if (e) begin
        m_instr = 0; m_pcd = m_pc; m_exc = 0; m_bd = 0;
      end else begin
        m_instr = adel ? 32'd0 : imem(m_pc);
        m_pcd = m_pc; m_exc = adel ? 5'd4 : 5'd0; m_bd = b;
        if (!adel) m_fc = m_fc + 1;
      end
      m_pc = (n != 0) ? n : m_pc + 32'd4;
    end
    exp_q.push_back({m_instr, m_pcd, m_exc, m_bd});
    @(posedge clk);
    #1;
    item = exp_q.pop_front();
    check("pc_F", pc_F, m_pc);
    check("instr_D", instr_D, item[69:38]);
    check("pc_D", pc_D, item[37:6]);
    check("excCode_D", {27'd0, excCode_D}, {27'd0, item[5:1]});
    check("bd_D", {31'd0, bd_D}, {31'd0, item[0]});
`ifdef FETCH_STAT_EN
    check("fetch_cnt", fetch_cnt, m_fc);
    check("stall_cnt", stall_cnt, m_sc);
`endif
  endtask

  logic [31:0] edges [4];
  logic [31:0] n_rand;

  initial begin
    edges[0] = 32'h2FFC; edges[1] = 32'h3000; edges[2] = 32'h6FFC; edges[3] = 32'h7000;
    m_pc = 0; m_instr = 0; m_pcd = 0; m_exc = 0; m_bd = 0; m_fc = 0; m_sc = 0;

    // reset state
    step(1, 0, 0, 0, 0, 0);
    check("reset_pc_F", pc_F, 32'h3000);
    check("reset_pc_D", pc_D, 32'h3000);
    check("reset_instr_D", instr_D, 32'd0);

    // sequential fetch
    step(0, 0, 0, 0, 0, 0);
    check("seq_pc_F", pc_F, 32'h3004);
    check("seq_instr_D", instr_D, imem(32'h3000));
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("seq_pc_F_3010", pc_F, 32'h3010);

    // branch with delay slot tagging
    step(0, 0, 0, 0, 1, 32'h3100);
    check("br_pc_D", pc_D, 32'h3010);
    check("br_bd_D", {31'd0, bd_D}, 32'd1);

    // stall hold, stall with pending eret, then release
    step(0, 0, 0, 0, 0, 32'h3020);
    step(0, 1, 0, 0, 0, 32'h3200);
    step(0, 1, 0, 1, 0, 32'h3200);
    check("stall_pc_F", pc_F, 32'h3020);
    check("stall_pc_D", pc_D, 32'h3100);
    step(0, 0, 0, 0, 0, 32'h3200);
    check("release_pc_F", pc_F, 32'h3200);

    // exception request overrides stall
    step(0, 1, 1, 1, 1, 32'h4180);
    check("req_pc_F", pc_F, 32'h4180);
    check("req_pc_D", pc_D, 32'h4180);
    check("req_instr_D", instr_D, 32'd0);

    // AdEL: misaligned, then above IM_HI
    step(0, 0, 0, 0, 0, 32'h3002);
    step(0, 0, 0, 0, 0, 32'h7000);
    check("adel1_exc", {27'd0, excCode_D}, 32'd4);
    check("adel1_pc_D", pc_D, 32'h3002);
    step(0, 0, 0, 0, 0, 0);
    check("adel2_exc", {27'd0, excCode_D}, 32'd4);
    check("adel2_pc_D", pc_D, 32'h7000);
    check("adel2_instr_D", instr_D, 32'd0);

    // eret squash
    step(0, 0, 0, 0, 0, 32'h3400);
    step(0, 0, 0, 1, 0, 32'h3404);
    check("eret_pc_F", pc_F, 32'h3404);
    check("eret_instr_D", instr_D, 32'd0);
    check("eret_pc_D", pc_D, 32'h3400);

    // PC wrap at 2^32, then reset mid-stall
    step(0, 0, 0, 0, 0, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0);
    check("wrap_pc_F", pc_F, 32'd0);
    step(0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 32'h5000);
    check("reset_mid_pc_F", pc_F, 32'h3000);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: n_rand = 32'd0;
        5: n_rand = $urandom_range(32'h0C00, 32'h1BFF) << 2;
        6: n_rand = ($urandom_range(32'h0C00, 32'h1BFF) << 2) | $urandom_range(1, 3);
        7: n_rand = $urandom;
        8: n_rand = edges[$urandom_range(0, 3)];
        default: n_rand = 32'hFFFF_FFFC;
      endcase
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
           $urandom_range(0, 1), n_rand);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
